// File: rtl/e203_dtcm_ram_bnk.sv
// ============================================================================
// Module   : e203_dtcm_ram_bnk
// Purpose  : Word-interleaved, power-managed DTCM SRAM with per-bank light
//            sleep and a shutdown handshake. Optional macro
//            E203_DTCM_RAM_OREG_EN adds an output register stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module e203_dtcm_ram_bnk #(
  parameter int DW       = 32,
  parameter int MW       = DW / 8,
  parameter int AW       = 15,
  parameter int NBANK    = 2,
  parameter int LS_IDLE  = 16,
  parameter int WAKE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sd,
  output logic             sd_ack,
  input  logic             req_vld,
  output logic             req_rdy,
  input  logic             req_we,
  input  logic [AW-1:0]    req_addr,
  input  logic [MW-1:0]    req_wem,
  input  logic [DW-1:0]    req_wdat,
  output logic             rsp_vld,
  output logic [DW-1:0]    rsp_rdat,
  output logic [NBANK-1:0] bank_ls
);

  localparam int BSH   = $clog2(NBANK);
  localparam int BW    = (NBANK > 1) ? BSH : 1;
  localparam int IW    = AW - BSH;
  localparam int DEPTH = 1 << IW;
  localparam int CW    = (LS_IDLE > 1) ? $clog2(LS_IDLE + 1) : 1;
  localparam int WW    = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;

  localparam logic [1:0] c_st_active = 2'd0;
  localparam logic [1:0] c_st_ls     = 2'd1;
  localparam logic [1:0] c_st_wake   = 2'd2;
  localparam logic [1:0] c_st_sd     = 2'd3;

  logic [BW-1:0]    w_bank;
  logic [IW-1:0]    w_idx;
  logic             w_acc;
  logic [NBANK-1:0] w_active;
  logic [NBANK-1:0] w_acc_b;
  logic [NBANK-1:0] w_in_sd;
  logic [DW-1:0]    w_rd_b [NBANK];
  logic [DW-1:0]    w_rd_sel;
  logic [DW-1:0]    w_rdat;
  logic             w_stage_busy;

  logic             r_rsp_vld;
  logic             r_rsp_we;
  logic [BW-1:0]    r_rsp_bank;
  logic             r_sd_ack;

  if (NBANK > 1) begin : g_bank_sel
    assign w_bank = req_addr[BW-1:0];
  end else begin : g_bank_one
    assign w_bank = '0;
  end

  assign w_idx   = req_addr[AW-1:BSH];
  assign req_rdy = w_active[w_bank] & ~sd;
  assign w_acc   = req_vld & req_rdy;

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [WW-1:0] r_wcnt;
    logic [DW-1:0] r_rd;
    logic [DW-1:0] mem [DEPTH];
    logic          w_hit;

    assign w_hit      = (w_bank == BW'(b));
    assign w_acc_b[b] = w_acc & w_hit;
    assign w_active[b] = (r_state == c_st_active);
    assign w_in_sd[b]  = (r_state == c_st_sd);
    assign bank_ls[b]  = (r_state != c_st_active);
    assign w_rd_b[b]   = r_rd;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state <= c_st_active;
        r_cnt   <= '0;
        r_wcnt  <= '0;
      end else begin
        case (r_state)
          c_st_active: begin
            if (sd) begin
              r_state <= c_st_sd;
              r_cnt   <= '0;
            end else if (w_acc_b[b]) begin
              r_cnt <= '0;
            end else if ((LS_IDLE != 0) && (r_cnt == CW'(LS_IDLE - 1))) begin
              r_state <= c_st_ls;
              r_cnt   <= '0;
            end else if (r_cnt != '1) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          c_st_ls: begin
            if (sd) begin
              r_state <= c_st_sd;
            end else if (req_vld && w_hit) begin
              r_state <= c_st_wake;
              r_wcnt  <= '0;
            end
          end
          c_st_wake: begin
            if (r_wcnt == WW'(WAKE_CYC - 1)) begin
              r_state <= c_st_active;
            end else begin
              r_wcnt <= r_wcnt + 1'b1;
            end
          end
          c_st_sd: begin
            if (!sd) begin
              r_state <= c_st_wake;
              r_wcnt  <= '0;
            end
          end
          default: r_state <= c_st_active;
        endcase
      end
    end

    // Array and read latch are deliberately not reset.
    always_ff @(posedge clk) begin
      if (w_acc_b[b] && req_we) begin
        for (int i = 0; i < MW; i++) begin
          if (req_wem[i]) mem[w_idx][8*i +: 8] <= req_wdat[8*i +: 8];
        end
      end
      if (w_acc_b[b] && !req_we) r_rd <= mem[w_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_vld  <= 1'b0;
      r_rsp_we   <= 1'b0;
      r_rsp_bank <= '0;
    end else begin
      r_rsp_vld <= w_acc;
      if (w_acc) begin
        r_rsp_we   <= req_we;
        r_rsp_bank <= w_bank;
      end
    end
  end

  assign w_rd_sel = w_rd_b[r_rsp_bank];

  // Unknown bits from never-written words are forced to zero.
  always_comb begin
    w_rdat = '0;
    if (r_rsp_vld && !r_rsp_we) begin
      for (int i = 0; i < DW; i++) w_rdat[i] = (w_rd_sel[i] === 1'b1);
    end
  end

`ifdef E203_DTCM_RAM_OREG_EN
  logic          r_o_vld;
  logic [DW-1:0] r_o_rdat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_o_vld  <= 1'b0;
      r_o_rdat <= '0;
    end else begin
      r_o_vld  <= r_rsp_vld;
      r_o_rdat <= w_rdat;
    end
  end

  assign rsp_vld      = r_o_vld;
  assign rsp_rdat     = r_o_rdat;
  assign w_stage_busy = r_rsp_vld | r_o_vld;
`else
  assign rsp_vld      = r_rsp_vld;
  assign rsp_rdat     = w_rdat;
  assign w_stage_busy = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sd_ack <= 1'b0;
    else     r_sd_ack <= sd & (&w_in_sd) & ~w_stage_busy;
  end

  assign sd_ack = r_sd_ack;

endmodule

`default_nettype wire

// File: tb/tb_e203_dtcm_ram_bnk.sv
// ============================================================================
// Module   : tb_e203_dtcm_ram_bnk
// Purpose  : Directed self-checking bench for e203_dtcm_ram_bnk.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_e203_dtcm_ram_bnk;

`ifdef E203_DTCM_RAM_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sd = 1'b0;
  logic        sd_ack;
  logic        req_vld = 1'b0;
  logic        req_rdy;
  logic        req_we = 1'b0;
  logic [14:0] req_addr = '0;
  logic [3:0]  req_wem = '0;
  logic [31:0] req_wdat = '0;
  logic        rsp_vld;
  logic [31:0] rsp_rdat;
  logic [1:0]  bank_ls;

  int checks = 0;
  int errors = 0;

  e203_dtcm_ram_bnk dut (
    .clk      (clk),
    .rst      (rst),
    .sd       (sd),
    .sd_ack   (sd_ack),
    .req_vld  (req_vld),
    .req_rdy  (req_rdy),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wem  (req_wem),
    .req_wdat (req_wdat),
    .rsp_vld  (rsp_vld),
    .rsp_rdat (rsp_rdat),
    .bank_ls  (bank_ls)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one request, wait (bounded) for acceptance, return in the response cycle.
  task automatic issue(input logic we, input logic [14:0] addr, input logic [3:0] wem,
                       input logic [31:0] wdat);
    int n;
    req_vld  = 1'b1;
    req_we   = we;
    req_addr = addr;
    req_wem  = wem;
    req_wdat = wdat;
    n = 0;
    @(negedge clk);
    while (!req_rdy && n < 20) begin
      step();
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("rdy_timeout", 32'd0, 32'd1);
    step();
    req_vld = 1'b0;
    repeat (LAT - 1) step();
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
    chk("rst_rsp_rdat", rsp_rdat, 32'd0);
    chk("rst_sd_ack", {31'd0, sd_ack}, 32'd0);
    chk("rst_bank_ls", {30'd0, bank_ls}, 32'd0);
    step();
    rst = 1'b0;

    // Idle: banks enter light sleep after exactly 16 idle cycles
    repeat (15) step();
    @(negedge clk);
    chk("idle15_ls", {30'd0, bank_ls}, 32'd0);
    step();
    @(negedge clk);
    chk("idle16_ls", {30'd0, bank_ls}, 32'd3);

    // Wake bank 1 with a read of a never-written word
    req_vld  = 1'b1;
    req_we   = 1'b0;
    req_addr = 15'h3;
    n = 0;
    while (!req_rdy && n < 10) begin
      n++;
      step();
      @(negedge clk);
    end
    chk("wake_rdy_low", n, 32'd3);
    chk("wake_bank_ls", {30'd0, bank_ls}, 32'd1);
    step();
    req_vld = 1'b0;
    @(negedge clk);
    chk("wake_rsp_vld", {31'd0, rsp_vld}, 32'd1);
    chk("unwritten_rd", rsp_rdat, 32'd0);

    // Byte-masked writes then readback
    issue(1'b1, 15'h10, 4'hF, 32'hDEADBEEF);
    issue(1'b1, 15'h10, 4'h1, 32'h000000AA);
    @(negedge clk);
    chk("wr_rsp_vld", {31'd0, rsp_vld}, 32'd1);
    chk("wr_rsp_rdat", rsp_rdat, 32'd0);
    issue(1'b0, 15'h10, 4'h0, 32'd0);
    @(negedge clk);
    chk("mask_rsp_vld", {31'd0, rsp_vld}, 32'd1);
    chk("mask_rd", rsp_rdat, 32'hDEADBEAA);

    // Back-to-back writes across both banks
    issue(1'b0, 15'h1, 4'h0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      req_vld  = 1'b1;
      req_we   = 1'b1;
      req_addr = 15'(i);
      req_wem  = 4'hF;
      req_wdat = 32'h11111111 * (i + 1);
      @(negedge clk);
      chk("b2b_rdy", {31'd0, req_rdy}, 32'd1);
      if (i > 0) chk("b2b_rsp_vld", {31'd0, rsp_vld}, 32'd1);
      step();
    end
    req_vld = 1'b0;
    @(negedge clk);
    chk("b2b_rsp_last", {31'd0, rsp_vld}, 32'd1);
    step();
    @(negedge clk);
    chk("b2b_rsp_done", {31'd0, rsp_vld}, 32'd0);
    issue(1'b0, 15'h2, 4'h0, 32'd0);
    @(negedge clk);
    chk("b2b_rd2", rsp_rdat, 32'h33333333);
    issue(1'b0, 15'h3, 4'h0, 32'd0);

    // Shutdown raised in the response cycle of an accepted read
    sd = 1'b1;
    @(negedge clk);
    chk("sd_rsp_vld", {31'd0, rsp_vld}, 32'd1);
    chk("sd_rsp_rdat", rsp_rdat, 32'h44444444);
    chk("sd_rdy", {31'd0, req_rdy}, 32'd0);
    step();
    @(negedge clk);
    chk("sd_ack_early", {31'd0, sd_ack}, 32'd0);
    chk("sd_bank_ls", {30'd0, bank_ls}, 32'd3);
    step();
    @(negedge clk);
    chk("sd_ack", {31'd0, sd_ack}, 32'd1);
    step();
    sd = 1'b0;
    step();
    @(negedge clk);
    chk("sd_ack_fall", {31'd0, sd_ack}, 32'd0);
    chk("sd_wake1", {30'd0, bank_ls}, 32'd3);
    step();
    @(negedge clk);
    chk("sd_wake2", {30'd0, bank_ls}, 32'd3);
    step();
    @(negedge clk);
    chk("sd_active", {30'd0, bank_ls}, 32'd0);
    chk("sd_active_rdy", {31'd0, req_rdy}, 32'd1);

    // Reset right after acceptance drops the pending response
    issue(1'b0, 15'h10, 4'h0, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_vld", {31'd0, rsp_vld}, 32'd0);
    chk("rst_mid_ls", {30'd0, bank_ls}, 32'd0);
    chk("rst_mid_ack", {31'd0, sd_ack}, 32'd0);
    step();
    rst = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
